// File: rtl/svga_scan_gen.sv
// 640x480@60 raster generator that maps each position into a centred 512x384 window
// as text-cell and graphics coordinates, with sync/DE delayed to match the pixel stage.
module svga_scan_gen #(
    parameter int H_WIN_START = 64,
    parameter int V_WIN_START = 48,
    parameter int PIPE_DELAY  = 4
) (
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic       width_64,
    output logic       show_border,
    output logic [6:0] char_column,
    output logic [6:0] char_line,
    output logic [4:0] subchar_line,
    output logic [3:0] subchar_pixel,
    output logic [8:0] graph_pixel,
    output logic [9:0] graph_line_2x,
    output logic [9:0] graph_line_3x,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_de,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_FIRST = 10'd656;
    localparam logic [9:0] H_SYNC_LAST  = 10'd751;
    localparam logic [9:0] V_LAST       = 10'd524;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_FIRST = 10'd490;
    localparam logic [9:0] V_SYNC_LAST  = 10'd491;
    localparam logic [9:0] H_WIN_FIRST  = 10'(H_WIN_START);
    localparam logic [9:0] H_WIN_LAST   = 10'(H_WIN_START + 511);
    localparam logic [9:0] V_WIN_FIRST  = 10'(V_WIN_START);
    localparam logic [9:0] V_WIN_LAST   = 10'(V_WIN_START + 383);

    logic [9:0] h_count, v_count, h_next, v_next;
    logic       line_end;
    logic       mode_64;
    logic       frame_wrap;
    logic [4:0] sub_line, sub_next;
    logic [6:0] cell_row, row_next;
    logic [9:0] acc3, acc_next;
    logic [1:0] phase, phase_next;
    logic       in_window;
    logic [8:0] win_x;
    logic [9:0] win_y;
    logic [PIPE_DELAY-1:0] hs_pipe, vs_pipe, de_pipe, fs_pipe;

    always_comb begin
        line_end = (h_count == H_LAST);
        h_next   = h_count + 10'd1;
        v_next   = v_count;
        if (line_end) begin
            h_next = 10'd0;
            v_next = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
        end
    end

    // Per-line cell and 4/3 line state for the upcoming position; restarts on the window's first line.
    always_comb begin
        sub_next   = sub_line;
        row_next   = cell_row;
        acc_next   = acc3;
        phase_next = phase;
        if (line_end) begin
            if (v_next == V_WIN_FIRST) begin
                sub_next   = 5'd0;
                row_next   = 7'd0;
                acc_next   = 10'd0;
                phase_next = 2'd0;
            end else begin
                if (sub_line == (mode_64 ? 5'd11 : 5'd23)) begin
                    sub_next = 5'd0;
                    row_next = cell_row + 7'd1;
                end else begin
                    sub_next = sub_line + 5'd1;
                end
                acc_next   = acc3 + ((phase == 2'd2) ? 10'd2 : 10'd1);
                phase_next = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
            end
        end
    end

    always_comb begin
        in_window = (h_next >= H_WIN_FIRST) && (h_next <= H_WIN_LAST) &&
                    (v_next >= V_WIN_FIRST) && (v_next <= V_WIN_LAST);
        win_x     = 9'(h_next - H_WIN_FIRST);
        win_y     = v_next - V_WIN_FIRST;
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            h_count    <= 10'd0;
            v_count    <= 10'd0;
            mode_64    <= 1'b0;
            frame_wrap <= 1'b0;
            sub_line   <= 5'd0;
            cell_row   <= 7'd0;
            acc3       <= 10'd0;
            phase      <= 2'd0;
        end else begin
            h_count    <= h_next;
            v_count    <= v_next;
            frame_wrap <= line_end && (v_count == V_LAST);
            sub_line   <= sub_next;
            cell_row   <= row_next;
            acc3       <= acc_next;
            phase      <= phase_next;
            if (v_count >= V_VISIBLE)
                mode_64 <= width_64;
        end
    end

    // Outputs are computed from the next position so they line up with the counters.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            show_border   <= 1'b1;
            char_column   <= 7'd0;
            char_line     <= 7'd0;
            subchar_line  <= 5'd0;
            subchar_pixel <= 4'd0;
            graph_pixel   <= 9'd0;
            graph_line_2x <= 10'd0;
            graph_line_3x <= 10'd0;
        end else if (in_window) begin
            show_border   <= 1'b0;
            char_column   <= mode_64 ? {1'b0, win_x[8:3]} : {2'b0, win_x[8:4]};
            char_line     <= row_next;
            subchar_line  <= sub_next;
            subchar_pixel <= mode_64 ? {1'b0, win_x[2:0]} : win_x[3:0];
            graph_pixel   <= win_x;
            graph_line_2x <= win_y;
            graph_line_3x <= acc_next;
        end else begin
            show_border   <= 1'b1;
            char_column   <= 7'd0;
            char_line     <= 7'd0;
            subchar_line  <= 5'd0;
            subchar_pixel <= 4'd0;
            graph_pixel   <= 9'd0;
            graph_line_2x <= 10'd0;
            graph_line_3x <= 10'd0;
        end
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            hs_pipe <= '1;
            vs_pipe <= '1;
            de_pipe <= '0;
            fs_pipe <= '0;
        end else begin
            hs_pipe[0] <= !((h_count >= H_SYNC_FIRST) && (h_count <= H_SYNC_LAST));
            vs_pipe[0] <= !((v_count >= V_SYNC_FIRST) && (v_count <= V_SYNC_LAST));
            de_pipe[0] <= (h_count < H_VISIBLE) && (v_count < V_VISIBLE);
            fs_pipe[0] <= frame_wrap;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
                de_pipe[i] <= de_pipe[i-1];
                fs_pipe[i] <= fs_pipe[i-1];
            end
        end
    end

    assign vga_hsync   = hs_pipe[PIPE_DELAY-1];
    assign vga_vsync   = vs_pipe[PIPE_DELAY-1];
    assign vga_de      = de_pipe[PIPE_DELAY-1];
    assign frame_start = fs_pipe[PIPE_DELAY-1];

endmodule

// File: tb/tb_svga_scan_gen.sv
// Directed bench for svga_scan_gen: reset behaviour, sync/DE timing, window corners,
// 4/3 line sequence and the frame-boundary text-width switch.
module tb_svga_scan_gen;

    localparam int PD    = 4;
    localparam int LINE  = 800;
    localparam int FRAME = 420000;

    logic       pixel_clock = 1'b0;
    logic       reset       = 1'b1;
    logic       width_64    = 1'b0;
    logic       show_border;
    logic [6:0] char_column, char_line;
    logic [4:0] subchar_line;
    logic [3:0] subchar_pixel;
    logic [8:0] graph_pixel;
    logic [9:0] graph_line_2x, graph_line_3x;
    logic       vga_hsync, vga_vsync, vga_de, frame_start;

    int    vectors     = 0;
    int    miscompares = 0;
    longint edges      = 0;

    svga_scan_gen #(.H_WIN_START(64), .V_WIN_START(48), .PIPE_DELAY(PD)) dut (
        .pixel_clock   (pixel_clock),
        .reset         (reset),
        .width_64      (width_64),
        .show_border   (show_border),
        .char_column   (char_column),
        .char_line     (char_line),
        .subchar_line  (subchar_line),
        .subchar_pixel (subchar_pixel),
        .graph_pixel   (graph_pixel),
        .graph_line_2x (graph_line_2x),
        .graph_line_3x (graph_line_3x),
        .vga_hsync     (vga_hsync),
        .vga_vsync     (vga_vsync),
        .vga_de        (vga_de),
        .frame_start   (frame_start)
    );

    always #5 pixel_clock = ~pixel_clock;

    // Edge count since reset release; the raster position after edge k is k mod 800 / line.
    always @(posedge pixel_clock or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_val, input logic w64);
        reset    = rst_val;
        width_64 = w64;
    endtask

    function automatic longint pos(input int h, input int v, input int frame);
        return longint'(frame) * FRAME + longint'(v) * LINE + h;
    endfunction

    task automatic goToEdge(input longint target);
        while (edges < target) @(negedge pixel_clock);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_border"}, int'(show_border), 1);
        checkOutput({tag, "_gpix"},   int'(graph_pixel), 0);
        checkOutput({tag, "_gl2x"},   int'(graph_line_2x), 0);
        checkOutput({tag, "_ccol"},   int'(char_column), 0);
        checkOutput({tag, "_hsync"},  int'(vga_hsync), 1);
        checkOutput({tag, "_vsync"},  int'(vga_vsync), 1);
        checkOutput({tag, "_de"},     int'(vga_de), 0);
        checkOutput({tag, "_fs"},     int'(frame_start), 0);
    endtask

    task automatic checkCells(input string tag, input int ccol, input int cline,
                              input int spix, input int sline);
        checkOutput({tag, "_ccol"},  int'(char_column), ccol);
        checkOutput({tag, "_cline"}, int'(char_line), cline);
        checkOutput({tag, "_spix"},  int'(subchar_pixel), spix);
        checkOutput({tag, "_sline"}, int'(subchar_line), sline);
    endtask

    int seq3x [7] = '{0, 1, 2, 4, 5, 6, 8};

    initial begin
        int hsFirst, hsSecond, hsLow, deFirst, deCount, vsLow, vsFirst, fsCount, fsFirst, deVblank;
        logic prevHs;

        applyStimulus(1'b1, 1'b0);
        repeat (2) @(negedge pixel_clock);
        checkResetValues("por");
        applyStimulus(1'b0, 1'b0);

        // Run into the middle of a frame, then reset asynchronously there.
        goToEdge(pos(300, 200, 0));
        checkOutput("mid_border", int'(show_border), 0);
        checkOutput("mid_gpix", int'(graph_pixel), 236);
        checkOutput("mid_de", int'(vga_de), 1);
        applyStimulus(1'b1, 1'b0);
        #1;
        checkResetValues("async");
        repeat (2) @(negedge pixel_clock);
        applyStimulus(1'b0, 1'b0);
        #1;
        checkResetValues("held");

        // First two lines after release: sync and DE timing.
        hsFirst = -1; hsSecond = -1; hsLow = 0; deFirst = -1; deCount = 0; vsLow = 0; fsCount = 0;
        prevHs = 1'b1;
        repeat (2 * LINE) begin
            @(negedge pixel_clock);
            if (!vga_hsync) begin
                hsLow++;
                if (prevHs && hsFirst < 0) hsFirst = int'(edges);
                else if (prevHs && hsSecond < 0) hsSecond = int'(edges);
            end
            prevHs = vga_hsync;
            if (vga_de) begin
                deCount++;
                if (deFirst < 0) deFirst = int'(edges);
            end
            if (!vga_vsync) vsLow++;
            if (frame_start) fsCount++;
        end
        checkOutput("de_first_edge", deFirst, PD);
        checkOutput("de_count_2lines", deCount, 1280);
        checkOutput("hs_first_fall", hsFirst, 656 + PD);
        checkOutput("hs_period", hsSecond - hsFirst, 800);
        checkOutput("hs_low_2lines", hsLow, 192);
        checkOutput("vs_low_top", vsLow, 0);
        checkOutput("fs_none_top", fsCount, 0);

        // Top-left window corner, 32-column mode.
        goToEdge(pos(63, 48, 0));
        checkOutput("pre_win_border", int'(show_border), 1);
        goToEdge(pos(64, 48, 0));
        checkOutput("tl_border", int'(show_border), 0);
        checkOutput("tl_gpix", int'(graph_pixel), 0);
        checkOutput("tl_gl2x", int'(graph_line_2x), 0);
        checkOutput("tl_gl3x", int'(graph_line_3x), 0);
        checkCells("tl", 0, 0, 0, 0);

        for (int y = 0; y < 7; y++) begin
            goToEdge(pos(64, 48 + y, 0));
            checkOutput($sformatf("gl3x_l%0d_start", y), int'(graph_line_3x), seq3x[y]);
            goToEdge(pos(575, 48 + y, 0));
            checkOutput($sformatf("gl3x_l%0d_end", y), int'(graph_line_3x), seq3x[y]);
        end

        goToEdge(pos(101, 78, 0));
        checkOutput("a_gl2x", int'(graph_line_2x), 30);
        checkOutput("a_gl3x", int'(graph_line_3x), 40);
        checkCells("a32", 2, 1, 5, 6);

        // Request 64-column cells mid-frame; this frame must stay 32-column.
        goToEdge(pos(10, 100, 0));
        applyStimulus(1'b0, 1'b1);
        goToEdge(pos(101, 150, 0));
        checkOutput("b_gl2x", int'(graph_line_2x), 102);
        checkOutput("b_gl3x", int'(graph_line_3x), 136);
        checkCells("b32", 2, 4, 5, 6);

        goToEdge(pos(575, 431, 0));
        checkOutput("br_border", int'(show_border), 0);
        checkOutput("br_gpix", int'(graph_pixel), 511);
        checkOutput("br_gl2x", int'(graph_line_2x), 383);
        checkOutput("br_gl3x", int'(graph_line_3x), 510);
        checkCells("br32", 31, 15, 15, 23);
        goToEdge(pos(576, 431, 0));
        checkOutput("past_r_border", int'(show_border), 1);
        checkOutput("past_r_gpix", int'(graph_pixel), 0);
        checkOutput("past_r_gl2x", int'(graph_line_2x), 0);
        checkOutput("past_r_gl3x", int'(graph_line_3x), 0);
        checkCells("past_r", 0, 0, 0, 0);
        goToEdge(pos(64, 432, 0));
        checkOutput("past_b_border", int'(show_border), 1);

        // Vertical sync window and blanking.
        goToEdge(pos(0, 489, 0));
        vsLow = 0; vsFirst = -1; deVblank = 0;
        while (edges < pos(0, 493, 0)) begin
            @(negedge pixel_clock);
            if (!vga_vsync) begin
                vsLow++;
                if (vsFirst < 0) vsFirst = int'(edges);
            end
            if (vga_de) deVblank++;
        end
        checkOutput("vs_low_count", vsLow, 1600);
        checkOutput("vs_first_fall", vsFirst, 490 * LINE + PD);
        checkOutput("de_in_vblank", deVblank, 0);

        // First frame_start after the mid-frame reset release.
        fsCount = 0; fsFirst = -1;
        while (edges < pos(20 + PD, 0, 1)) begin
            @(negedge pixel_clock);
            if (frame_start) begin
                fsCount++;
                if (fsFirst < 0) fsFirst = int'(edges);
            end
        end
        checkOutput("fs_first_edge", fsFirst, FRAME + PD);
        checkOutput("fs_pulse_width", fsCount, 1);

        // Next frame picks up 64-column cells.
        goToEdge(pos(101, 78, 1));
        checkCells("a64", 4, 2, 5, 6);
        checkOutput("a64_gl3x", int'(graph_line_3x), 40);
        goToEdge(pos(575, 431, 1));
        checkOutput("br64_gpix", int'(graph_pixel), 511);
        checkCells("br64", 63, 31, 7, 11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
